// File: rtl/tdm_demux8.sv
// Receive side of the 8:1 TDM bit link: locks onto the frame marker, gathers one
// bit per slot and presents each completed frame in parallel with a valid strobe.
module tdm_demux8 #(
    parameter int N  = 8,
    parameter int SW = 3,
    parameter int EW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inD,
    input  logic          inEn,
    input  logic          inFrame,
    input  logic          inClr,
    output logic [N-1:0]  Y,
    output logic          outValid,
    output logic          outLock,
    output logic [SW-1:0] outSlot,
    output logic          outErr,
    output logic [EW-1:0] outErrCnt
);

    typedef enum logic {HUNT, RUN} state_t;

    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

    state_t        state, stateNext;
    logic [N-1:0]  hold, holdNext;
    logic [N-1:0]  yNext;
    logic          validNext;
    logic [SW-1:0] slotNext;
    logic          errFlag;
    logic          errNext;
    logic [EW-1:0] cntNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            hold      <= '0;
            Y         <= '0;
            outValid  <= 1'b0;
            outSlot   <= '0;
            outErr    <= 1'b0;
            outErrCnt <= '0;
        end else begin
            state     <= stateNext;
            hold      <= holdNext;
            Y         <= yNext;
            outValid  <= validNext;
            outSlot   <= slotNext;
            outErr    <= errNext;
            outErrCnt <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        holdNext  = hold;
        yNext     = Y;
        validNext = 1'b0;
        slotNext  = outSlot;
        errFlag   = 1'b0;
        if (inEn) begin
            unique case (state)
                HUNT: begin
                    if (inFrame) begin
                        holdNext[0] = inD;
                        slotNext    = SW'(1);
                        stateNext   = RUN;
                    end
                end
                RUN: begin
                    if (inFrame && outSlot != '0) begin
                        // Early marker: drop the partial frame and restart on it.
                        errFlag     = 1'b1;
                        holdNext    = '0;
                        holdNext[0] = inD;
                        slotNext    = SW'(1);
                    end else if (!inFrame && outSlot == '0) begin
                        errFlag   = 1'b1;
                        stateNext = HUNT;
                        slotNext  = '0;
                    end else begin
                        holdNext[outSlot] = inD;
                        slotNext          = outSlot + SW'(1);
                        if (outSlot == LAST_SLOT) begin
                            yNext     = holdNext;
                            validNext = 1'b1;
                        end
                    end
                end
                default: stateNext = HUNT;
            endcase
        end
    end

    // A new error on the same edge as inClr takes precedence over the clear.
    always_comb begin
        errNext = outErr;
        cntNext = outErrCnt;
        if (errFlag) begin
            errNext = 1'b1;
            if (inClr)
                cntNext = EW'(1);
            else if (outErrCnt != '1)
                cntNext = outErrCnt + EW'(1);
        end else if (inClr) begin
            errNext = 1'b0;
            cntNext = '0;
        end
    end

    assign outLock = (state == RUN);

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed test-plan steps followed by
// randomized traffic, all checked against a slot/frame-level reference model.
module tb_tdm_demux8;

    localparam int N  = 8;
    localparam int SW = 3;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inD, inEn, inFrame, inClr;
    logic [N-1:0]  Y;
    logic          outValid, outLock, outErr;
    logic [SW-1:0] outSlot;
    logic [EW-1:0] outErrCnt;

    tdm_demux8 #(.N(N), .SW(SW), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n), .inD(inD), .inEn(inEn), .inFrame(inFrame),
        .inClr(inClr), .Y(Y), .outValid(outValid), .outLock(outLock),
        .outSlot(outSlot), .outErr(outErr), .outErrCnt(outErrCnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: lock flag, next slot number, partial frame as an integer.
    bit mLock;
    int mSlot, mPart, mY, mValid, mErr, mCnt;

    task automatic modelReset();
        mLock = 0; mSlot = 0; mPart = 0; mY = 0; mValid = 0; mErr = 0; mCnt = 0;
    endtask

    task automatic modelError(input bit clr);
        mErr = 1;
        mCnt = clr ? 1 : ((mCnt + 1 > 15) ? 15 : mCnt + 1);
    endtask

    task automatic modelStep(input bit d, input bit en, input bit fr, input bit clr);
        bit err;
        err = 0;
        mValid = 0;
        if (en) begin
            if (!mLock) begin
                if (fr) begin mPart = d; mSlot = 1; mLock = 1; end
            end else if (fr && mSlot != 0) begin
                err = 1; mPart = d; mSlot = 1;
            end else if (!fr && mSlot == 0) begin
                err = 1; mLock = 0; mSlot = 0;
            end else begin
                if (d) mPart = mPart | (1 << mSlot);
                else   mPart = mPart & ~(1 << mSlot);
                if (mSlot == N - 1) begin mY = mPart & 'hFF; mValid = 1; end
                mSlot = (mSlot + 1) % N;
            end
        end
        if (err) modelError(clr);
        else if (clr) begin mErr = 0; mCnt = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".Y"},     {24'b0, Y},         mY);
        chk({tag, ".valid"}, {31'b0, outValid},  mValid);
        chk({tag, ".lock"},  {31'b0, outLock},   {31'b0, mLock});
        chk({tag, ".slot"},  {29'b0, outSlot},   mSlot);
        chk({tag, ".err"},   {31'b0, outErr},    mErr);
        chk({tag, ".cnt"},   {28'b0, outErrCnt}, mCnt);
    endtask

    task automatic step(input string tag, input bit d, input bit en, input bit fr, input bit clr);
        inD = d; inEn = en; inFrame = fr; inClr = clr;
        modelStep(d, en, fr, clr);
        @(posedge clk); #1;
        checkAll(tag);
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] v, input bit gaps);
        for (int k = 0; k < N; k++) begin
            step(tag, v[k], 1'b1, k == 0, 1'b0);
            if (gaps) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic doReset();
        inD = 0; inEn = 0; inFrame = 0; inClr = 0;
        rst_n = 1'b0;
        modelReset();
        #1 checkAll("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; inD = 0; inEn = 0; inFrame = 0; inClr = 0;
        #2;
        doReset();

        // Frame A5, continuous strobes.
        sendFrame("a5", 8'hA5, 1'b0);
        chk("a5_const", {24'b0, Y}, 32'hA5);
        chk("a5_pulse", {31'b0, outValid}, 1);
        step("a5_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_one_cycle", {31'b0, outValid}, 0);

        // Back-to-back frames with strobe gaps.
        sendFrame("3c", 8'h3C, 1'b1);
        sendFrame("c3", 8'hC3, 1'b0);
        chk("c3_const", {24'b0, Y}, 32'hC3);
        chk("c3_slot_wrap", {29'b0, outSlot}, 0);

        // HUNT ignores unmarked bits, then locks on the marker.
        doReset();
        for (int i = 0; i < 3; i++) step("hunt_ign", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("hunt_unlocked", {31'b0, outLock}, 0);
        step("hunt_lock", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("hunt_locked", {31'b0, outLock}, 1);
        chk("hunt_slot1", {29'b0, outSlot}, 1);

        // Early marker at slot 4 resyncs; next frame comes from the new marker.
        for (int k = 1; k < 4; k++) step("mis_pre", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mis_mark", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mis_err", {31'b0, outErr}, 1);
        chk("mis_cnt", {28'b0, outErrCnt}, 1);
        chk("mis_novalid", {31'b0, outValid}, 0);
        for (int k = 1; k < N; k++) step("mis_fin", 1'(k & 1), 1'b1, 1'b0, 1'b0);
        chk("mis_frame", {24'b0, Y}, 32'hAA);

        // Missing marker after a good frame drops lock.
        step("miss", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("miss_unlock", {31'b0, outLock}, 0);
        chk("miss_cnt", {28'b0, outErrCnt}, 2);

        // Saturation via repeated early markers.
        step("sat_lock", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_15", {28'b0, outErrCnt}, 15);
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_err", {31'b0, outErr}, 0);
        chk("clr_cnt", {28'b0, outErrCnt}, 0);
        step("sat_again", 1'b0, 1'b1, 1'b1, 1'b0);
        step("clr_vs_err", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_vs_err_cnt", {28'b0, outErrCnt}, 1);
        chk("clr_vs_err_flag", {31'b0, outErr}, 1);

        // Asynchronous reset mid-frame at slot 5.
        sendFrame("pre_rst", 8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) step("rst_part", 1'b1, 1'b1, k == 0, 1'b0);
        #2 rst_n = 1'b0;
        modelReset();
        #1 checkAll("async_rst");
        chk("async_rst_y", {24'b0, Y}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sendFrame("post_rst", 8'h96, 1'b0);
        chk("post_rst_y", {24'b0, Y}, 32'h96);

        // Randomized traffic: mostly well-framed, occasional marker faults and clears.
        for (int i = 0; i < 1500; i++) begin
            bit en, fr, d, clr;
            en  = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom);
            fr  = (mSlot == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if ($urandom_range(0, 29) == 0) fr = ~fr;
            clr = ($urandom_range(0, 39) == 0);
            step("rand", d, en, fr, clr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
